tinyalu_arbiter: RTL and testbench
==================================

# tinyalu_arbiter

Round-robin arbiter and sequencer that shares one TinyALU datapath between `NREQ` independent requesters. Each request is an (A, B, op) triple. The block grants one request at a time, drives the ALU start/done handshake, and returns the 16-bit result to the winning requester with a one-cycle response strobe. No-op and unsupported opcodes complete internally without touching the ALU. The block sits between requester logic (or bench agents) and the TinyALU instance.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT`, default 15: maximum cycles to wait for `alu_done`. Used only when the timeout feature is compiled in.

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request pending
- `req_a`  in  NREQ*8  operand A per requester, requester i at bits [8i+7:8i]
- `req_b`  in  NREQ*8  operand B per requester, same packing as `req_a`
- `req_op`  in  NREQ*3  opcode per requester, requester i at bits [3i+2:3i]
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse
- `rsp_valid`  out  NREQ  one-hot, one-cycle response strobe to the owning requester
- `rsp_result`  out  16  result; valid only while any `rsp_valid` bit is set
- `rsp_err`  out  1  error flag qualifying the response
- `alu_a`  out  8  ALU operand A
- `alu_b`  out  8  ALU operand B
- `alu_op`  out  3  ALU opcode
- `alu_start`  out  1  ALU start
- `alu_done`  in  1  ALU done pulse
- `alu_result`  in  16  ALU result

## Operation
- Opcodes: 000 no_op, 001 add, 010 and, 011 xor, 100 mul. Opcodes 101, 110 and 111 (111 = rst_op) are illegal for requesters; a requester can never reset the shared ALU.
- States: IDLE, BUSY, RESP.
- IDLE, with any `req_valid` set:
  - The picker selects the first set bit, searching from `last_grant+1` and wrapping modulo NREQ.
  - `req_ready[g]` pulses for one cycle; A, B, op and the grant index are registered.
  - Legal ALU op: next state BUSY.
  - no_op or illegal op: next state RESP.
- IDLE with no request: stay in IDLE; all outputs idle.
- BUSY:
  - `alu_start`=1 and `alu_a`/`alu_b`/`alu_op` are held at the registered values.
  - `alu_done` sampled high: register `alu_result`; `alu_start`=0 from the next cycle; next state RESP.
- RESP:
  - `rsp_valid[g]`=1 for exactly one cycle.
  - `rsp_result`: ALU result for a completed ALU op; 0 for no_op, illegal op or timeout.
  - `rsp_err`: 1 for illegal op or timeout; otherwise 0.
  - `last_grant` ← g; next state IDLE.
- Requester contract: hold `req_*` stable from `req_valid` rise until `req_ready`; issue at most one outstanding request per requester.
- `req_valid` deasserting before grant is legal; the request is not serviced.
- A requester that re-asserts immediately after its response has lowest priority for the next grant (round-robin fairness).
- `alu_*` outputs are 0 whenever the state is not BUSY.

## Timing
- Reset values: state IDLE, `last_grant`=NREQ-1 (requester 0 wins first); every output 0.
- Reset mid-operation: outputs clear asynchronously; the in-flight operation is discarded and no response is issued.
- Cycle numbering, with `req_ready` at cycle 0:
  - `alu_start` rises at cycle 1.
  - With done sampled at cycle k, `alu_start` falls and `rsp_valid` is set at cycle k+1.
  - The next grant can occur at cycle k+2.
- no_op or illegal op: `rsp_valid` at cycle 1; next grant at cycle 2.
- Simultaneous requests: exactly one grant per IDLE cycle; losers keep `req_valid` high.
- `alu_done` outside BUSY is ignored.

## Configuration
- `TINYALU_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in BUSY.
  - If `TIMEOUT` cycles elapse without `alu_done`: `alu_start` drops and the FSM enters RESP with `rsp_err`=1, `rsp_result`=0.
- Not defined: BUSY waits indefinitely, and the `TIMEOUT` parameter is unused.

## Structure
- Shared package `tinyalu_pkg`: `operation_t` enum (the encodings above), arbiter state enum, and an `is_alu_op()` function.
- One sub-module, `tinyalu_rr_picker`: combinational round-robin selection. Inputs: request vector and `last_grant`. Outputs: `grant_valid` and the grant index.

## Test plan
- Single requester 1, add A=8'd200, B=8'd100 → `req_ready[1]` at cycle 0, `rsp_valid[1]` with `rsp_result`=16'd300, `rsp_err`=0.
- Requesters 0..3 all request mul 8'hFF×8'hFF together after reset → grants in order 0,1,2,3; each response is 16'hFE01; `alu_start` drops between operations.
- Requester 2 no_op, then requester 3 op 3'b111 → responses at cycle 1 with result 0; err 0 for the no_op and 1 for the illegal op; `alu_start` never asserts.
- Requester 0 streaming back-to-back while requester 3 waits → requester 3 is granted immediately after requester 0's first response.
- `reset` asserted while BUSY on a mul → all outputs 0 at once, no `rsp_valid` is issued, and after release requester 0 is granted first.
- With `TINYALU_ARB_TIMEOUT_EN` and `alu_done` tied low → `rsp_err`=1 and `rsp_result`=0 exactly `TIMEOUT`+1 cycles after `alu_start` rises.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared TinyALU opcode and arbiter state definitions
package tinyalu_pkg;
  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    RST_OP = 3'b111
  } operation_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  function automatic logic is_alu_op(input logic [2:0] op);
    return op inside {ADD_OP, AND_OP, XOR_OP, MUL_OP};
  endfunction
endpackage

// File: rtl/tinyalu_rr_picker.sv
// tinyalu_rr_picker: combinational round-robin pick, first request after last_grant
module tinyalu_rr_picker import tinyalu_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant
);
  always_comb begin
    grant_valid = |req;
    grant = '0;
    for (int i = NREQ; i > 0; i--)
      if (req[(int'(last_grant) + i) % NREQ]) grant = IW'((int'(last_grant) + i) % NREQ);
  end
endmodule

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin TinyALU sharer; define TINYALU_ARB_TIMEOUT_EN to bound the alu_done wait
module tinyalu_arbiter import tinyalu_pkg::*; #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_result,
  output logic              rsp_err,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [15:0]       alu_result
);
  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  arb_state_t state;
  logic [IW-1:0] last_grant, g_q, sel;
  logic sel_valid, err_q, to, done;
  logic [7:0] a_q, b_q;
  logic [2:0] op_q, sel_op;
  tinyalu_rr_picker #(.NREQ(NREQ)) u_picker (
    .req(req_valid),
    .last_grant(last_grant),
    .grant_valid(sel_valid),
    .grant(sel)
  );
  assign sel_op = req_op[3*sel +: 3];
`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign to = alu_start && cnt == CW'(TIMEOUT);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (alu_start && !done) ? cnt + 1'b1 : '0;
`else
  assign to = 1'b0;
`endif
  // done only counts once start is actually on the bus, so early or stray pulses are ignored
  assign done = alu_start && (alu_done || to);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      last_grant <= IW'(NREQ - 1);
      g_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      err_q <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      alu_start <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
      case (state)
        IDLE: if (sel_valid) begin
          req_ready <= ONE << sel;
          g_q <= sel;
          a_q <= req_a[8*sel +: 8];
          b_q <= req_b[8*sel +: 8];
          op_q <= sel_op;
          err_q <= sel_op != NO_OP;
          state <= is_alu_op(sel_op) ? BUSY : RESP;
        end
        BUSY: if (done) begin
          {alu_start, alu_a, alu_b, alu_op} <= '0;
          rsp_valid <= ONE << g_q;
          rsp_result <= alu_done ? alu_result : '0;
          rsp_err <= !alu_done;
          last_grant <= g_q;
          state <= IDLE;
        end else begin
          alu_start <= 1'b1;
          alu_a <= a_q;
          alu_b <= b_q;
          alu_op <= op_q;
        end
        RESP: begin
          rsp_valid <= ONE << g_q;
          rsp_err <= err_q;
          last_grant <= g_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: directed checks of grant order, handshake timing, reset and error responses
module tb_tinyalu_arbiter;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 15;
  localparam int LAT = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*8-1:0] req_a = '0, req_b = '0;
  logic [NREQ*3-1:0] req_op = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [15:0] rsp_result;
  logic rsp_err;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic alu_start;
  logic alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  tinyalu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result)
  );
  always #5 clk = ~clk;
  typedef struct {int idx; int cyc; logic [15:0] res; logic err;} ev_t;
  ev_t gnt_q[$], rsp_q[$];
  int cyc = 0, n_cmp = 0, n_err = 0, start_cyc = 0, start_rises = 0;
  logic start_d = 1'b0, alu_mute = 1'b0;
  logic [7:0] sa = '0, sb = '0;
  logic [2:0] sop = '0;
  logic [NREQ-1:0] stream = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int oh(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (|req_ready) begin
      gnt_q.push_back(ev_t'{oh(req_ready), cyc, 16'h0, 1'b0});
      req_valid = req_valid & ~req_ready;
    end
    if (|rsp_valid) begin
      rsp_q.push_back(ev_t'{oh(rsp_valid), cyc, rsp_result, rsp_err});
      check("rsp_onehot", $countones(rsp_valid), 1);
      req_valid = req_valid | (rsp_valid & stream);
    end
    if (alu_start && !start_d) begin
      start_rises++;
      start_cyc = cyc;
      sa = alu_a;
      sb = alu_b;
      sop = alu_op;
    end
    start_d = alu_start;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_op[3*i +: 3] = op;
    req_valid[i] = 1'b1;
  endtask
  task automatic clr();
    gnt_q.delete();
    rsp_q.delete();
    start_rises = 0;
  endtask
  task automatic wait_n(input string tag, input int want, input bit rsp);
    for (int t = 0; t < 300 && (rsp ? rsp_q.size() : gnt_q.size()) < want; t++) tick();
    check(tag, rsp ? rsp_q.size() : gnt_q.size(), want);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    stream = '0;
    ticks(3);
    reset = 1'b0;
    start_d = 1'b0;
    clr();
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_rsp"}, {rsp_valid, rsp_result, rsp_err}, 0);
    check({tag, "_alu"}, {alu_start, alu_a, alu_b, alu_op}, 0);
  endtask
  // bench-side ALU: answers every start after LAT cycles unless muted
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (alu_start && !alu_mute) begin
        c++;
        if (c == LAT) begin
          c = 0;
          alu_done = 1'b1;
          alu_result = alu_op == 3'd1 ? 16'(alu_a) + 16'(alu_b) :
                       alu_op == 3'd2 ? 16'(alu_a & alu_b) :
                       alu_op == 3'd3 ? 16'(alu_a ^ alu_b) :
                       alu_op == 3'd4 ? 16'(alu_a) * 16'(alu_b) : 16'hDEAD;
        end
      end else c = 0;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    ticks(3);
    check_idle("rst_held");
    reset = 1'b0;
    ticks(2);
    check_idle("rst_idle");
    set_req(1, 8'd200, 8'd100, 3'b001);
    wait_n("t1_rsp_cnt", 1, 1);
    check("t1_gnt_idx", gnt_q[0].idx, 1);
    check("t1_rsp_idx", rsp_q[0].idx, 1);
    check("t1_result", rsp_q[0].res, 16'd300);
    check("t1_err", rsp_q[0].err, 0);
    check("t1_latency", rsp_q[0].cyc - gnt_q[0].cyc, 3);
    check("t1_start_cyc", start_cyc - gnt_q[0].cyc, 1);
    check("t1_alu_ops", {sa, sb, sop}, {8'd200, 8'd100, 3'b001});
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'hFF, 8'hFF, 3'b100);
    wait_n("t2_rsp_cnt", 4, 1);
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("t2_gnt%0d", i), gnt_q[i].idx, i);
      check($sformatf("t2_rsp%0d", i), {rsp_q[i].idx[3:0], rsp_q[i].res, 3'b000, rsp_q[i].err}, {4'(i), 16'hFE01, 4'h0});
    end
    check("t2_start_rises", start_rises, 4);
    check("t2_next_gap", gnt_q[1].cyc - rsp_q[0].cyc, 1);
    clr();
    set_req(1, 8'd5, 8'd6, 3'b101);
    wait_n("t3_rsp1", 1, 1);
    set_req(2, 8'd7, 8'd9, 3'b000);
    wait_n("t3_rsp2", 2, 1);
    set_req(3, 8'hAA, 8'h55, 3'b111);
    wait_n("t3_rsp3", 3, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_idx%0d", i), rsp_q[i].idx, i + 1);
      check($sformatf("t3_res%0d", i), rsp_q[i].res, 0);
      check($sformatf("t3_lat%0d", i), rsp_q[i].cyc - gnt_q[i].cyc, 1);
      check($sformatf("t3_err%0d", i), rsp_q[i].err, i != 1);
    end
    check("t3_no_start", start_rises, 0);
    clr();
    stream[0] = 1'b1;
    set_req(0, 8'd10, 8'd20, 3'b001);
    set_req(3, 8'hF0, 8'h3C, 3'b011);
    wait_n("t4_gnt_cnt", 3, 0);
    stream[0] = 1'b0;
    wait_n("t4_rsp_cnt", 3, 1);
    check("t4_order", {gnt_q[0].idx[3:0], gnt_q[1].idx[3:0], gnt_q[2].idx[3:0]}, 12'h030);
    check("t4_r0_res", rsp_q[0].res, 16'd30);
    check("t4_r3", {rsp_q[1].idx[3:0], rsp_q[1].res}, {4'd3, 16'h00CC});
    check("t4_r3_gap", gnt_q[1].cyc - rsp_q[0].cyc, 1);
    clr();
    set_req(2, 8'h12, 8'h34, 3'b100);
    for (int t = 0; t < 50 && !alu_start; t++) tick();
    check("t5_busy", alu_start, 1);
    #2 reset = 1'b1;
    #1 check_idle("t5_async");
    req_valid = '0;
    ticks(2);
    reset = 1'b0;
    ticks(3);
    check("t5_no_rsp", rsp_q.size(), 0);
    clr();
    set_req(3, 8'd1, 8'd2, 3'b001);
    set_req(0, 8'd3, 8'd4, 3'b001);
    wait_n("t5_rsp_cnt", 2, 1);
    check("t5_first", gnt_q[0].idx, 0);
    check("t5_second", gnt_q[1].idx, 3);
    check("t5_results", {rsp_q[0].res, rsp_q[1].res}, {16'd7, 16'd3});
`ifdef TINYALU_ARB_TIMEOUT_EN
    clr();
    alu_mute = 1'b1;
    set_req(1, 8'd3, 8'd3, 3'b100);
    wait_n("t6_rsp_cnt", 1, 1);
    check("t6_lat", rsp_q[0].cyc - start_cyc, TIMEOUT + 1);
    check("t6_res", rsp_q[0].res, 0);
    check("t6_err", rsp_q[0].err, 1);
    alu_mute = 1'b0;
`endif
    ticks(2);
    check_idle("end_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
